// File: rtl/rv_shifter_pipe_pkg.sv
// Shared definitions for the pipelined shifter.
//   shift_op_e : operation encodings carried on op_i (101..111 reserved).
//   lvl_count  : number of log-shifter levels owned by a given stage.
//   first_lvl  : highest level index (shift by 2**idx) owned by a given stage.
// Levels run from SHAMT_W-1 (shift by XLEN/2) down to 0 (shift by 1). When the
// levels do not divide evenly, the earlier stages each take one extra level.
package rv_shifter_pipe_pkg;

    typedef enum logic [2:0] {
        OP_SLL = 3'b000,
        OP_SRL = 3'b001,
        OP_SRA = 3'b010,
        OP_ROL = 3'b011,
        OP_ROR = 3'b100
    } shift_op_e;

    function automatic int lvl_count(input int shamt_w, input int stages, input int idx);
        return shamt_w / stages + ((idx < (shamt_w % stages)) ? 1 : 0);
    endfunction

    function automatic int first_lvl(input int shamt_w, input int stages, input int idx);
        int acc;
        acc = shamt_w - 1;
        for (int k = 0; k < idx; k++) acc -= lvl_count(shamt_w, stages, k);
        return acc;
    endfunction

endpackage

// File: rtl/rv_shifter_stage.sv
// One pipeline stage of the log shifter.
//   Applies NUM_LVL consecutive levels (FIRST_LVL down to FIRST_LVL-NUM_LVL+1)
//   to src_data and registers the result with its sideband.
//   clk, rst_n      : clock, asynchronous active-low reset
//   en              : pipeline advance enable
//   flush           : clears the valid bit regardless of en
//   src_* / dst_*   : incoming / registered valid, data, shamt, op, fill, tag
module rv_shifter_stage
    import rv_shifter_pipe_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int FIRST_LVL = 4,
    parameter int NUM_LVL   = 3,
    parameter int TAG_W     = 5,
    localparam int SHAMT_W  = $clog2(XLEN)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               flush,
    input  logic               src_vld,
    input  logic [XLEN-1:0]    src_data,
    input  logic [SHAMT_W-1:0] src_shamt,
    input  logic [2:0]         src_op,
    input  logic               src_fill,
    input  logic [TAG_W-1:0]   src_tag,
    output logic               dst_vld,
    output logic [XLEN-1:0]    dst_data,
    output logic [SHAMT_W-1:0] dst_shamt,
    output logic [2:0]         dst_op,
    output logic               dst_fill,
    output logic [TAG_W-1:0]   dst_tag
);

    // Single level: shift/rotate by 2**lvl. SRA pulls in the fill bit captured
    // from the original operand, so the sign survives across stages.
    function automatic logic [XLEN-1:0] shift_lvl(input logic [2:0] op,
                                                  input logic [XLEN-1:0] d,
                                                  input logic fill,
                                                  input int lvl);
        int                  amt;
        logic [2*XLEN-1:0]   ext;
        logic [XLEN-1:0]     r;
        amt = 1 << lvl;
        ext = {{XLEN{fill}}, d} >> amt;
        case (op)
            OP_SLL:  r = d << amt;
            OP_SRL:  r = d >> amt;
            OP_SRA:  r = ext[XLEN-1:0];
            OP_ROL:  r = (d << amt) | (d >> (XLEN - amt));
            OP_ROR:  r = (d >> amt) | (d << (XLEN - amt));
            default: r = d;  // reserved ops pass the operand through
        endcase
        return r;
    endfunction

    logic [NUM_LVL:0][XLEN-1:0] lvl_d;

    assign lvl_d[0] = src_data;

    for (genvar j = 0; j < NUM_LVL; j++) begin : g_lvl
        localparam int L = FIRST_LVL - j;
        assign lvl_d[j+1] = src_shamt[L] ? shift_lvl(src_op, lvl_d[j], src_fill, L) : lvl_d[j];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dst_vld   <= 1'b0;
            dst_data  <= '0;
            dst_shamt <= '0;
            dst_op    <= '0;
            dst_fill  <= 1'b0;
            dst_tag   <= '0;
        end else begin
            if (flush)   dst_vld <= 1'b0;
            else if (en) dst_vld <= src_vld;
            // Payload only moves with a real operation; bubbles leave it parked.
            if (en && src_vld) begin
                dst_data  <= lvl_d[NUM_LVL];
                dst_shamt <= src_shamt;
                dst_op    <= src_op;
                dst_fill  <= src_fill;
                dst_tag   <= src_tag;
            end
        end
    end

endmodule

// File: rtl/rv_shifter_pipe.sv
// Pipelined barrel shifter / rotator with valid-ready handshake.
//   clk_i, rst_n_i          : clock, asynchronous active-low reset
//   in_valid_i/in_ready_o   : request handshake (op_i, data_i, shamt_i, tag_i)
//   flush_i                 : drop everything in flight, including this cycle's input
//   out_valid_o/out_ready_i : result handshake (out_data_o, out_tag_o)
// The whole pipe advances together whenever the output slot is free or being
// drained, so in_ready_o never looks at in_valid_i.
module rv_shifter_pipe
    import rv_shifter_pipe_pkg::*;
#(
    parameter int XLEN   = 32,
    parameter int STAGES = 2,
    parameter int TAG_W  = 5,
    localparam int SHAMT_W = $clog2(XLEN)
) (
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               in_valid_i,
    output logic               in_ready_o,
    input  logic [2:0]         op_i,
    input  logic [XLEN-1:0]    data_i,
    input  logic [SHAMT_W-1:0] shamt_i,
    input  logic [TAG_W-1:0]   tag_i,
    input  logic               flush_i,
    output logic               out_valid_o,
    input  logic               out_ready_i,
    output logic [XLEN-1:0]    out_data_o,
    output logic [TAG_W-1:0]   out_tag_o
);

    logic                              en;
    logic [STAGES:0]                   vld_pipe;
    logic [STAGES:0][XLEN-1:0]         data_pipe;
    logic [STAGES:0][SHAMT_W-1:0]      shamt_pipe;
    logic [STAGES:0][2:0]              op_pipe;
    logic [STAGES:0]                   fill_pipe;
    logic [STAGES:0][TAG_W-1:0]        tag_pipe;

    assign en         = out_ready_i || !out_valid_o;
    assign in_ready_o = en;

    assign vld_pipe[0]   = in_valid_i;
    assign data_pipe[0]  = data_i;
    assign shamt_pipe[0] = shamt_i;
    assign op_pipe[0]    = op_i;
    assign fill_pipe[0]  = (op_i == OP_SRA) && data_i[XLEN-1];
    assign tag_pipe[0]   = tag_i;

    for (genvar s = 0; s < STAGES; s++) begin : g_stage
        rv_shifter_stage #(
            .XLEN      (XLEN),
            .FIRST_LVL (first_lvl(SHAMT_W, STAGES, s)),
            .NUM_LVL   (lvl_count(SHAMT_W, STAGES, s)),
            .TAG_W     (TAG_W)
        ) u_stage (
            .clk       (clk_i),
            .rst_n     (rst_n_i),
            .en        (en),
            .flush     (flush_i),
            .src_vld   (vld_pipe[s]),
            .src_data  (data_pipe[s]),
            .src_shamt (shamt_pipe[s]),
            .src_op    (op_pipe[s]),
            .src_fill  (fill_pipe[s]),
            .src_tag   (tag_pipe[s]),
            .dst_vld   (vld_pipe[s+1]),
            .dst_data  (data_pipe[s+1]),
            .dst_shamt (shamt_pipe[s+1]),
            .dst_op    (op_pipe[s+1]),
            .dst_fill  (fill_pipe[s+1]),
            .dst_tag   (tag_pipe[s+1])
        );
    end

    assign out_valid_o = vld_pipe[STAGES];
    assign out_data_o  = data_pipe[STAGES];
    assign out_tag_o   = tag_pipe[STAGES];

    // Control sideband of the last stage has no consumer.
    logic unused_tail;
    assign unused_tail = ^{shamt_pipe[STAGES], op_pipe[STAGES], fill_pipe[STAGES]};

endmodule

// File: tb/tb_rv_shifter_pipe.sv
module tb_rv_shifter_pipe;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        in_valid, in_ready, flush, out_valid, out_ready;
    logic [2:0]  op;
    logic [31:0] data, out_data;
    logic [4:0]  shamt, tag, out_tag;

    logic        in_valid64, in_ready64, flush64, out_valid64, out_ready64;
    logic [2:0]  op64;
    logic [63:0] data64, out_data64;
    logic [5:0]  shamt64;
    logic [4:0]  tag64, out_tag64;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    rv_shifter_pipe #(.XLEN(32), .STAGES(2), .TAG_W(5)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(in_valid), .in_ready_o(in_ready),
        .op_i(op), .data_i(data), .shamt_i(shamt), .tag_i(tag), .flush_i(flush),
        .out_valid_o(out_valid), .out_ready_i(out_ready), .out_data_o(out_data),
        .out_tag_o(out_tag)
    );

    rv_shifter_pipe #(.XLEN(64), .STAGES(3), .TAG_W(5)) dut64 (
        .clk_i(clk), .rst_n_i(rst_n), .in_valid_i(in_valid64), .in_ready_o(in_ready64),
        .op_i(op64), .data_i(data64), .shamt_i(shamt64), .tag_i(tag64), .flush_i(flush64),
        .out_valid_o(out_valid64), .out_ready_i(out_ready64), .out_data_o(out_data64),
        .out_tag_o(out_tag64)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Reference: whole-operation arithmetic on the operand.
    function automatic logic [31:0] ref_shift(input logic [2:0] o, input logic [31:0] d, input int s);
        logic [31:0] r;
        case (o)
            3'd0:    r = d << s;
            3'd1:    r = d >> s;
            3'd2:    r = 32'($signed(d) >>> s);
            3'd3:    r = (s == 0) ? d : ((d << s) | (d >> (32 - s)));
            3'd4:    r = (s == 0) ? d : ((d >> s) | (d << (32 - s)));
            default: r = d;
        endcase
        return r;
    endfunction

    // Scoreboard: every accepted op must come out once, in order, with the
    // modelled result; a stalled output must not change.
    logic [31:0] exp_d[$];
    logic [4:0]  exp_t[$];
    bit          prev_stall = 0;
    logic [31:0] prev_d;
    logic [4:0]  prev_t;

    always @(negedge clk) begin
        if (!rst_n) begin
            exp_d.delete(); exp_t.delete(); prev_stall = 0;
        end else begin
            if (prev_stall) begin
                total++;
                if (out_valid !== 1'b1 || out_data !== prev_d || out_tag !== prev_t) begin
                    bad++;
                    $display("FAIL stall_hold: got v=%0b d=%h t=%0d want v=1 d=%h t=%0d",
                             out_valid, out_data, out_tag, prev_d, prev_t);
                end
            end
            if (out_valid && out_ready) begin
                total++;
                if (exp_d.size() == 0) begin
                    bad++;
                    $display("FAIL spurious_out: got d=%h t=%0d want no result", out_data, out_tag);
                end else begin
                    if (out_data !== exp_d[0] || out_tag !== exp_t[0]) begin
                        bad++;
                        $display("FAIL sb_result: got d=%h t=%0d want d=%h t=%0d",
                                 out_data, out_tag, exp_d[0], exp_t[0]);
                    end
                    void'(exp_d.pop_front()); void'(exp_t.pop_front());
                end
            end
            if (flush) begin
                exp_d.delete(); exp_t.delete();
            end else if (in_valid && in_ready) begin
                exp_d.push_back(ref_shift(op, data, int'(shamt)));
                exp_t.push_back(tag);
            end
            prev_stall = out_valid && !out_ready && !flush;
            prev_d = out_data;
            prev_t = out_tag;
        end
    end

    task automatic test_reset();
        rst_n = 1'b0; in_valid = 1'b1; out_ready = 1'b0; flush = 1'b0;
        op = 3'd0; data = 32'hFFFF_FFFF; shamt = 5'd1; tag = 5'd3;
        repeat (3) @(posedge clk);
        @(negedge clk);
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", out_valid); end
        total++; if (out_data !== 32'h0) begin bad++; $display("FAIL rst_data: got %h want 0", out_data); end
        total++; if (out_tag !== 5'h0) begin bad++; $display("FAIL rst_tag: got %h want 0", out_tag); end
        total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b want 1", in_ready); end
        total++; if (out_valid64 !== 1'b0 || out_data64 !== 64'h0) begin
            bad++; $display("FAIL rst_64: got v=%b d=%h want v=0 d=0", out_valid64, out_data64);
        end
        @(posedge clk); #1;
        rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    endtask

    task automatic test_directed();
        logic [2:0]  ops [6] = '{3'd2, 3'd3, 3'd4, 3'd0, 3'd6, 3'd1};
        logic [31:0] ds  [6] = '{32'h8000_0000, 32'h8000_0001, 32'h8000_0001,
                                 32'h1234_5678, 32'hDEAD_BEEF, 32'h8000_0000};
        logic [4:0]  ss  [6] = '{5'd31, 5'd4, 5'd4, 5'd0, 5'd5, 5'd31};
        logic [31:0] ex  [6] = '{32'hFFFF_FFFF, 32'h0000_0018, 32'h1800_0000,
                                 32'h1234_5678, 32'hDEAD_BEEF, 32'h0000_0001};
        for (int i = 0; i < 6; i++) begin
            int  c_acc;
            bit  seen;
            @(posedge clk); #1;
            in_valid = 1'b1; op = ops[i]; data = ds[i]; shamt = ss[i]; tag = 5'(10 + i); out_ready = 1'b1;
            @(negedge clk);
            c_acc = cyc;
            @(posedge clk); #1;
            in_valid = 1'b0;
            seen = 0;
            for (int w = 0; w < 8 && !seen; w++) begin
                @(negedge clk);
                if (out_valid) seen = 1;
            end
            total++;
            if (!seen || (cyc - c_acc) != 2) begin
                bad++; $display("FAIL dir_latency[%0d]: got %0d want 2 (seen=%0b)", i, cyc - c_acc, seen);
            end
            total++;
            if (out_data !== ex[i] || out_tag !== 5'(10 + i)) begin
                bad++; $display("FAIL dir_data[%0d]: got %h t=%0d want %h t=%0d", i, out_data, out_tag, ex[i], 10 + i);
            end
        end
    endtask

    task automatic test_back_to_back();
        int          idx = 1, got = 0, stall_left = 0;
        bit          seen = 0;
        logic [31:0] snap_d = '0;
        logic [4:0]  snap_t = '0;
        flush = 1'b0;
        for (int k = 0; k < 40 && got < 4; k++) begin
            @(posedge clk); #1;
            if (out_valid && !seen) begin
                seen = 1; stall_left = 3; snap_d = out_data; snap_t = out_tag;
            end
            out_ready = (stall_left == 0);
            in_valid  = (idx <= 4);
            op = 3'($urandom_range(0, 4)); data = $urandom; shamt = 5'($urandom); tag = 5'(idx);
            @(negedge clk);
            if (stall_left > 0) begin
                total++;
                if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_data !== snap_d || out_tag !== 5'd1) begin
                    bad++;
                    $display("FAIL b2b_hold: got rdy=%b v=%b d=%h t=%0d want rdy=0 v=1 d=%h t=1",
                             in_ready, out_valid, out_data, out_tag, snap_d);
                end
                stall_left--;
            end
            if (in_valid && in_ready) idx++;
            if (out_valid && out_ready) begin
                total++;
                if (out_tag !== 5'(got + 1)) begin
                    bad++; $display("FAIL b2b_order: got tag %0d want %0d", out_tag, got + 1);
                end
                got++;
            end
        end
        total++;
        if (got != 4 || !seen) begin bad++; $display("FAIL b2b_count: got %0d want 4", got); end
        @(posedge clk); #1;
        in_valid = 1'b0; out_ready = 1'b1;
    endtask

    task automatic test_flush();
        bit any;
        @(posedge clk); #1;
        out_ready = 1'b0; in_valid = 1'b1; op = 3'd0; data = 32'h1; shamt = 5'd3; tag = 5'd20;
        @(posedge clk); #1;
        op = 3'd1; data = 32'hF0; tag = 5'd21;
        @(posedge clk); #1;
        op = 3'd3; data = 32'h5; tag = 5'd22; flush = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid: got %b want 0", out_valid); end
        @(posedge clk); #1;
        out_ready = 1'b1;
        any = 0;
        repeat (6) begin
            @(negedge clk);
            if (out_valid) any = 1;
        end
        total++;
        if (any) begin bad++; $display("FAIL flush_leak: got a result want none"); end
    endtask

    task automatic test_reset_mid();
        int c_acc;
        bit any;
        @(posedge clk); #1;
        out_ready = 1'b1; in_valid = 1'b1; op = 3'd0; data = 32'hA5; shamt = 5'd2; tag = 5'd25;
        @(posedge clk); #1;
        tag = 5'd26;
        @(posedge clk); #1;
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        total++;
        if (out_valid !== 1'b0 || out_data !== 32'h0 || out_tag !== 5'h0 || in_ready !== 1'b1) begin
            bad++;
            $display("FAIL async_rst: got v=%b d=%h t=%0d rdy=%b want v=0 d=0 t=0 rdy=1",
                     out_valid, out_data, out_tag, in_ready);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        in_valid = 1'b1; op = 3'd4; data = 32'h0000_0003; shamt = 5'd1; tag = 5'd27;
        @(negedge clk);
        c_acc = cyc;
        total++;
        if (in_ready !== 1'b1) begin bad++; $display("FAIL post_rst_ready: got %b want 1", in_ready); end
        @(posedge clk); #1;
        in_valid = 1'b0;
        any = 0;
        for (int w = 0; w < 6; w++) begin
            @(negedge clk);
            if (out_valid && out_tag !== 5'd27) any = 1;
            if (cyc - c_acc == 2) begin
                total++;
                if (out_valid !== 1'b1 || out_data !== 32'h8000_0001) begin
                    bad++; $display("FAIL post_rst_op: got v=%b d=%h want v=1 d=80000001", out_valid, out_data);
                end
            end
        end
        total++;
        if (any) begin bad++; $display("FAIL stale_after_rst: got stale result want none"); end
    endtask

    task automatic test_random();
        for (int k = 0; k < 400; k++) begin
            @(posedge clk); #1;
            in_valid  = ($urandom_range(0, 3) != 0);
            op        = 3'($urandom_range(0, 7));
            data      = $urandom;
            shamt     = ($urandom_range(0, 7) == 0) ? 5'd0 : 5'($urandom);
            tag       = 5'($urandom);
            out_ready = ($urandom_range(0, 3) != 0);
            flush     = ($urandom_range(0, 39) == 0);
        end
        @(posedge clk); #1;
        in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
        repeat (6) @(posedge clk);
        @(negedge clk);
        total++;
        if (exp_d.size() != 0) begin bad++; $display("FAIL rand_drain: got %0d pending want 0", exp_d.size()); end
    endtask

    task automatic test_xlen64();
        logic [2:0]  o64 [2] = '{3'd1, 3'd3};
        logic [63:0] d64 [2] = '{64'hFFFF_0000_0000_0000, 64'h8000_0000_0000_0001};
        logic [5:0]  s64 [2] = '{6'd48, 6'd4};
        logic [63:0] e64 [2] = '{64'h0000_0000_0000_FFFF, 64'h0000_0000_0000_0018};
        for (int i = 0; i < 2; i++) begin
            int c_acc;
            bit seen;
            @(posedge clk); #1;
            in_valid64 = 1'b1; op64 = o64[i]; data64 = d64[i]; shamt64 = s64[i]; tag64 = 5'(i + 1);
            @(negedge clk);
            c_acc = cyc;
            @(posedge clk); #1;
            in_valid64 = 1'b0;
            seen = 0;
            for (int w = 0; w < 10 && !seen; w++) begin
                @(negedge clk);
                if (out_valid64) seen = 1;
            end
            total++;
            if (!seen || (cyc - c_acc) != 3) begin
                bad++; $display("FAIL x64_latency[%0d]: got %0d want 3", i, cyc - c_acc);
            end
            total++;
            if (out_data64 !== e64[i] || out_tag64 !== 5'(i + 1)) begin
                bad++; $display("FAIL x64_data[%0d]: got %h want %h", i, out_data64, e64[i]);
            end
        end
    endtask

    initial begin
        in_valid64 = 1'b0; op64 = '0; data64 = '0; shamt64 = '0; tag64 = '0;
        flush64 = 1'b0; out_ready64 = 1'b1;
        test_reset();
        test_directed();
        test_back_to_back();
        test_flush();
        test_reset_mid();
        test_random();
        test_xlen64();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
